hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the two-operand forwarding/load-use unit. Supports NUM_SRC source operands, a DEPTH-stage in-flight window and per-instruction result latency.
- Tracks every in-flight register-writing instruction from EX to the RF write stage.
- For each issuing instruction, drives a per-source forwarding select and a stall/bubble request.
- Sits between decode and the EX operand muxes.

Parameters:
- NUM_SRC, 2, source operands checked per issuing instruction
- DEPTH, 4, in-flight stages tracked (pipe[0]=EX ... pipe[DEPTH-1]=last stage before RF write)
- REG_W, 5, register address width; register 0 is never a hazard
- LAT_W, 2, width of result-latency field

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- issue_valid_i  in  1  decode holds a valid instruction
- issue_writes_rf_i  in  1  issuing instruction writes RF
- issue_rd_i  in  REG_W  destination register
- issue_lat_i  in  LAT_W  cycles after entering pipe[0] until result is forwardable
- issue_src_i  in  NUM_SRC*REG_W  source registers, packed
- issue_src_used_i  in  NUM_SRC  per-source "operand read" flag
- hold_i  in  1  external freeze (memory busy); scoreboard does not advance
- flush_i  in  1  squash: pipe[0] receives a bubble on the next edge
- stall_o  out  1  decode must hold; bubble inserted into EX
- fwd_sel_o  out  NUM_SRC*FS_W  FS_W=$clog2(DEPTH+1); 0=RF, k+1=stage k
- stall_cnt_o  out  32  stall statistics (see Optional Feature)

Behaviour:
- Entry per stage = {valid, rd, rdy_cnt}. Only instructions with issue_writes_rf_i=1 and rd!=0 create a valid entry; all other instructions enter as an invalid entry.
- Reset: all entries invalid, rdy_cnt=0. Consequently stall_o=0, fwd_sel_o=0, stall_cnt_o=0. Reset asserted mid-operation discards all entries on that edge.
- Match rule: source s matches stage k iff issue_src_used_i[s], src!=0, pipe[k].valid and pipe[k].rd==src. The youngest match (smallest k) wins. No match gives fwd_sel=0.
- Ready rule: the winning entry is ready iff rdy_cnt==0. If ready, fwd_sel=k+1. If not ready, fwd_sel=0 and the source is blocked.
- stall_o = issue_valid_i & any source blocked. This output is combinational, zero latency. fwd_sel_o is also combinational and is valid only when stall_o=0.
- Advance, each edge with !hold_i:
  - pipe[k+1] <= pipe[k] with rdy_cnt saturating-decremented.
  - The entry leaving pipe[DEPTH-1] retires. The RF is write-before-read, so retiring producers need no forwarding.
- pipe[0] is loaded by priority:
  - bubble if flush_i or stall_o or !issue_valid_i;
  - otherwise the issuing instruction, with rdy_cnt=issue_lat_i.
- hold_i=1: all entries are frozen, rdy_cnt is not decremented, and flush_i is ignored. The requester keeps flush_i high until hold_i drops. stall_o is still computed.
- Latency convention: ALU lat=0 (forwardable from EX). Load lat=1, giving exactly one bubble on an immediately-following use. lat >= DEPTH is illegal; an assertion fires.
- Two sources naming the same register resolve identically.

Optional Feature:
- Macro HAZ_STALL_STATS_EN.
- Defined: stall_cnt_o increments on each edge with stall_o=1 and hold_i=0, saturating at 32'hFFFF_FFFF, and is cleared by reset.
- Undefined: no counter logic; stall_cnt_o is tied to 0.

Decomposition:
- Shared definitions package holds:
  - typedef hz_entry_s {valid, rd, rdy_cnt};
  - FWD_RF=0 constant;
  - FS_W function.
- One sub-module, hazard_src_match: youngest-match priority encoder for one source over DEPTH entries, returning {fwd_sel, blocked}. It is instantiated NUM_SRC times via generate.

Test Plan:
- Reset then idle: stall_o=0 and all fwd_sel=0 for 3 cycles, including with issue_valid_i=1 and srcs=r3,r4.
- add r5 (lat 0) then sub using r5 as src0: stall_o=0, fwd_sel[0]=1. One cycle later a third instruction using r5: fwd_sel=2.
- load r7 (lat 1) then use r7 as src1: stall_o=1 for exactly 1 cycle, bubble in pipe[0], then fwd_sel[1]=2.
- Two writers to r9 in flight at pipe[0] and pipe[2], consumer reads r9: fwd_sel=1 (youngest). A source of r0 with a pending r0 writer gives fwd_sel=0 and no stall.
- Load r2 issued, hold_i=1 for 3 cycles: stall_o stays 1 with no decrement. After hold drops, stall clears 1 cycle later. flush_i during hold has no effect.
- With HAZ_STALL_STATS_EN: 5 load-use stalls give stall_cnt_o=5. Reset mid-stall gives stall_cnt_o=0 and stall_o=0 on the next cycle.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard.
// Entry field widths are fixed here; the top's REG_W/LAT_W must match them.
package hazard_scoreboard_pkg;
  localparam int HZ_REG_W = 5;
  localparam int HZ_LAT_W = 2;
  localparam int FWD_RF   = 0;

  typedef struct packed {
    logic                valid;
    logic [HZ_REG_W-1:0] rd;
    logic [HZ_LAT_W-1:0] rdy_cnt;
  } hz_entry_s;

  function automatic int fs_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// Youngest-match priority encoder for one source operand over the in-flight window.
// Returns a forwarding select (0 = RF, k+1 = stage k) and a blocked flag.
module hazard_src_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int FS_W  = 3
) (
  input  logic [HZ_REG_W-1:0]   src_i,
  input  logic                  used_i,
  input  hz_entry_s [DEPTH-1:0] pipe_i,
  output logic [FS_W-1:0]       fwd_sel_o,
  output logic                  blocked_o
);
  logic found;

  always_comb begin
    fwd_sel_o = FS_W'(FWD_RF);
    blocked_o = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && used_i && src_i != '0 && pipe_i[k].valid && pipe_i[k].rd == src_i) begin
        found = 1'b1;
        // An unready producer blocks the source; older entries are ignored.
        if (pipe_i[k].rdy_cnt == '0) fwd_sel_o = FS_W'(k + 1);
        else                         blocked_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight register-writer scoreboard: per-source forwarding select and stall request.
// Optional stall statistics counter enabled by defining HAZ_STALL_STATS_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 4,
  parameter int REG_W   = HZ_REG_W,
  parameter int LAT_W   = HZ_LAT_W,
  localparam int FS_W   = fs_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid_i,
  input  logic                     issue_writes_rf_i,
  input  logic [REG_W-1:0]         issue_rd_i,
  input  logic [LAT_W-1:0]         issue_lat_i,
  input  logic [NUM_SRC*REG_W-1:0] issue_src_i,
  input  logic [NUM_SRC-1:0]       issue_src_used_i,
  input  logic                     hold_i,
  input  logic                     flush_i,
  output logic                     stall_o,
  output logic [NUM_SRC*FS_W-1:0]  fwd_sel_o,
  output logic [31:0]              stall_cnt_o
);
  hz_entry_s [DEPTH-1:0] pipe_q, pipe_d;
  logic [NUM_SRC-1:0]    blocked;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    hazard_src_match #(.DEPTH(DEPTH), .FS_W(FS_W)) u_match (
      .src_i     (issue_src_i[s*REG_W +: REG_W]),
      .used_i    (issue_src_used_i[s]),
      .pipe_i    (pipe_q),
      .fwd_sel_o (fwd_sel_o[s*FS_W +: FS_W]),
      .blocked_o (blocked[s])
    );
  end

  assign stall_o = issue_valid_i & (|blocked);

  always_comb begin
    pipe_d = pipe_q;
    if (!hold_i) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        pipe_d[k] = pipe_q[k-1];
        if (pipe_q[k-1].rdy_cnt != '0)
          pipe_d[k].rdy_cnt = pipe_q[k-1].rdy_cnt - HZ_LAT_W'(1);
      end
      // Non-writers, r0 writers, stalled and flushed slots all enter as bubbles.
      pipe_d[0] = '0;
      if (issue_valid_i && !flush_i && !stall_o && issue_writes_rf_i && issue_rd_i != '0)
        pipe_d[0] = '{valid: 1'b1, rd: issue_rd_i, rdy_cnt: issue_lat_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

`ifdef HAZ_STALL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && !hold_i && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

  // A result can never be forwardable later than the window it travels through.
  a_lat_legal: assert property (@(posedge clk) disable iff (reset)
    (issue_valid_i && issue_writes_rf_i) |-> (32'(issue_lat_i) < DEPTH));
endmodule
